// File: rtl/led_pwm_fader.sv
// led_pwm_fader
//   Fades an LED between off and full brightness when the on/off request
//   changes. A free-running step divider paces the ramp one duty level per
//   tick, and a free-running PWM counter turns the duty level into a
//   registered PWM drive.
//
//   Build option: define LED_FADE_GAMMA_EN to drive the PWM compare from a
//   squared (gamma-corrected) duty value. This adds one register stage, so
//   pwm_out lags duty by 2 cycles instead of 1. Duty, state and busy behave
//   the same in both builds.
//
//   Parameters
//     PWM_BITS  width of duty and of the PWM counter (2..12)
//     STEP_DIV  clk cycles per duty step (1..65535)
//
//   Ports
//     clk      in   clock, all state changes on the rising edge
//     reset    in   synchronous, active-high
//     ledpin   in   on/off request (registered upstream, same clock)
//     pwm_out  out  registered PWM drive
//     duty     out  current brightness level, 0..2^PWM_BITS-1
//     state    out  FSM state, encoded as below
//     busy     out  high while ramping (UP or DOWN)
//
//   state | meaning
//   ------+-------------------------------------------------
//   OFF=0 | dark, duty held at 0
//   UP=1  | ramping up one level per tick
//   ON=2  | full brightness, duty held at MAX
//   DOWN=3| ramping down one level per tick
module led_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ledpin,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          state,
  output logic                busy
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] MAX_M1   = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  state_t              cur_st, nxt_st;
  logic [PWM_BITS-1:0] duty_q, nxt_duty;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] cmp;
  logic                tick;

  assign tick = (div_cnt == DIV_LAST);

  // Step divider and PWM counter run regardless of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
      pwm_cnt <= pwm_cnt + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st <= ST_OFF;
      duty_q <= '0;
    end else begin
      cur_st <= nxt_st;
      duty_q <= nxt_duty;
    end
  end

  // A direction reversal wins over a coincident tick, so duty never jumps
  // when the request flips mid-ramp. The duty==MAX / duty==0 guards in the
  // ramp states cover reversals that land at an end stop, keeping duty
  // from wrapping.
  always_comb begin
    nxt_st   = cur_st;
    nxt_duty = duty_q;
    unique case (cur_st)
      ST_OFF: begin
        nxt_duty = '0;
        if (ledpin) nxt_st = ST_UP;
      end
      ST_UP: begin
        if (!ledpin) begin
          nxt_st = ST_DOWN;
        end else if (tick) begin
          if (duty_q == MAX) begin
            nxt_st = ST_ON;
          end else begin
            nxt_duty = duty_q + ONE;
            if (duty_q == MAX_M1) nxt_st = ST_ON;
          end
        end
      end
      ST_ON: begin
        nxt_duty = MAX;
        if (!ledpin) nxt_st = ST_DOWN;
      end
      ST_DOWN: begin
        if (ledpin) begin
          nxt_st = ST_UP;
        end else if (tick) begin
          if (duty_q == '0) begin
            nxt_st = ST_OFF;
          end else begin
            nxt_duty = duty_q - ONE;
            if (duty_q == ONE) nxt_st = ST_OFF;
          end
        end
      end
      default: begin
        nxt_st   = ST_OFF;
        nxt_duty = '0;
      end
    endcase
  end

`ifdef LED_FADE_GAMMA_EN
  // Square at full width, keep the upper half: cmp = duty^2 / 2^PWM_BITS.
  logic [2*PWM_BITS-1:0] duty_sq;
  logic [PWM_BITS-1:0]   cmp_q;

  assign duty_sq = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};

  always_ff @(posedge clk) begin
    if (reset) cmp_q <= '0;
    else       cmp_q <= duty_sq[2*PWM_BITS-1:PWM_BITS];
  end

  assign cmp = cmp_q;
`else
  assign cmp = duty_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) pwm_out <= 1'b0;
    else       pwm_out <= (pwm_cnt < cmp);
  end

  assign duty  = duty_q;
  assign state = cur_st;
  assign busy  = (cur_st == ST_UP) || (cur_st == ST_DOWN);

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_BITS=4, STEP_DIV=2 (MAX=15).
// Edge numbers in the comments count rising edges since reset released;
// the divider starts at 0 there, so ticks land on even edges.
module tb_led_pwm_fader;

  localparam int PW = 4;
  localparam int SD = 2;

`ifdef LED_FADE_GAMMA_EN
  localparam int EXP_HI_FULL = 14;
`else
  localparam int EXP_HI_FULL = 15;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ledpin;
  logic          pwm_out;
  logic [PW-1:0] duty;
  logic [1:0]    state;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int hi;

  led_pwm_fader #(.PWM_BITS(PW), .STEP_DIV(SD)) dut (
    .clk     (clk),
    .reset   (reset),
    .ledpin  (ledpin),
    .pwm_out (pwm_out),
    .duty    (duty),
    .state   (state),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    ledpin = 1'b0;
    step(5);
    reset = 1'b0;

    // idle after reset: everything stays at zero for 100 cycles
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("idle", int'({pwm_out, duty, state, busy}), 0);
    end

    // ramp up, edge 101..130
    ledpin = 1'b1;
    step(1);                         // 101
    chk("up_state", state, 1);
    chk("up_duty0", duty, 0);
    chk("up_busy", busy, 1);
    step(27);                        // 128
    chk("up_d14", duty, 14);
    chk("up_st14", state, 1);
    step(1);                         // 129, no tick
    chk("up_hold14", duty, 14);
    step(1);                         // 130, tick to MAX
    chk("on_duty", duty, 15);
    chk("on_state", state, 2);
    chk("on_busy", busy, 0);
    step(2);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      hi += int'(pwm_out);
    end
    chk("on_hi16", hi, EXP_HI_FULL);   // edge 148

    // ramp down, edge 149..178
    ledpin = 1'b0;
    step(1);                         // 149
    chk("dn_state", state, 3);
    chk("dn_duty15", duty, 15);
    chk("dn_busy", busy, 1);
    step(1);                         // 150
    chk("dn_d14", duty, 14);
    step(27);                        // 177
    chk("dn_d1", duty, 1);
    chk("dn_st1", state, 3);
    step(1);                         // 178
    chk("off_duty", duty, 0);
    chk("off_state", state, 0);
    chk("off_busy", busy, 0);
    step(1);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      hi += int'(pwm_out);
    end
    chk("off_hi32", hi, 0);          // edge 211

    // reversal on a tick at duty 7
    ledpin = 1'b1;
    step(1);                         // 212
    chk("rv_up", state, 1);
    step(15);                        // 227
    chk("rv_d7", duty, 7);
    ledpin = 1'b0;
    step(1);                         // 228, tick edge
    chk("rv_dn_state", state, 3);
    chk("rv_dn_d7", duty, 7);
    step(2);                         // 230
    chk("rv_dn_d6", duty, 6);
    ledpin = 1'b1;
    step(1);                         // 231
    chk("rv_up_state", state, 1);
    chk("rv_up_d6", duty, 6);
    step(1);                         // 232
    chk("rv_up_d7", duty, 7);
    step(4);                         // 236
    chk("pre_rst_d9", duty, 9);

    // reset mid-ramp with ledpin still high
    reset = 1'b1;
    step(1);                         // 237
    chk("rst_duty", duty, 0);
    chk("rst_state", state, 0);
    chk("rst_pwm", pwm_out, 0);
    reset = 1'b0;
    step(1);                         // first edge after release
    chk("post_rst_up", state, 1);
    chk("post_rst_d0", duty, 0);
    step(1);                         // divider restarted at 0: tick here
    chk("post_rst_d1", duty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 Parameter PWM_BITS, default 8, width of duty and PWM counter; legal 2..12.
REQ-002 Parameter STEP_DIV, default 4096, clk cycles per duty step; legal 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ledpin  input  1  on/off request, driven by the blink stage's registered output, same clk domain.
REQ-006 pwm_out  output  1  registered PWM drive to the LED.
REQ-007 duty  output  PWM_BITS  current brightness level.
REQ-008 state  output  2  FSM state: OFF=0, UP=1, ON=2, DOWN=3.
REQ-009 busy  output  1  high while state is UP or DOWN.

Function
REQ-010 MAX SHALL equal 2^PWM_BITS-1; duty SHALL stay within 0..MAX and never wrap.
REQ-011 The step divider SHALL run freely 0..STEP_DIV-1, wrap to 0, and assert an internal tick in the cycle it equals STEP_DIV-1, independent of state.
REQ-012 The PWM counter SHALL run freely 0..MAX and wrap to 0.
REQ-013 pwm_out SHALL be registered as (pwm_cnt < cmp), one cycle of latency; cmp=duty unless REQ-027 applies.
REQ-014 duty=0 SHALL give pwm_out constantly low; duty=MAX SHALL give MAX high cycles per 2^PWM_BITS.
REQ-015 OFF: ledpin=1 -> UP next cycle; duty held at 0.
REQ-016 UP: on tick, duty increments by 1; the tick taking duty from MAX-1 to MAX SHALL also move state to ON in the same edge.
REQ-017 UP: ledpin=0 -> DOWN next cycle, starting from the current duty with no jump.
REQ-018 ON: duty held at MAX; ledpin=0 -> DOWN next cycle.
REQ-019 DOWN: on tick, duty decrements by 1; the tick taking duty from 1 to 0 SHALL also move state to OFF.
REQ-020 DOWN: ledpin=1 -> UP next cycle, starting from the current duty.
REQ-021 A direction reversal (REQ-017, REQ-020) coinciding with a tick SHALL take priority; duty is unchanged in that cycle.
REQ-022 busy SHALL be a combinational decode of the state register.

Reset
REQ-023 reset=1 SHALL force, at the next rising edge: state=OFF, duty=0, step divider=0, PWM counter=0, pwm_out=0.
REQ-024 Reset asserted mid-ramp SHALL abort the ramp with no residual duty.
REQ-025 On the first edge after reset deasserts, ledpin=1 SHALL move the FSM to UP.

Configuration
REQ-026 Macro LED_FADE_GAMMA_EN selects gamma correction of the compare value.
REQ-027 When LED_FADE_GAMMA_EN is defined: cmp=(duty*duty)>>PWM_BITS, computed at full 2*PWM_BITS width before truncation, and registered so that pwm_out latency becomes 2 cycles.
REQ-028 When LED_FADE_GAMMA_EN is undefined: cmp=duty (linear), latency 1 cycle; duty, state and busy behaviour SHALL be identical in both builds.

Verification (PWM_BITS=4, STEP_DIV=2, MAX=15, linear build unless stated)
REQ-029 Hold reset for 5 cycles, ledpin=0, then release and run 100 cycles -> pwm_out=0, duty=0, state=OFF, busy=0 throughout.
REQ-030 Raise ledpin and hold it -> state=UP next cycle; duty reaches 15 after 15 ticks (about 30 cycles), state=ON in the same edge; afterwards pwm_out is high for 15 of every 16 cycles.
REQ-031 From ON, drop ledpin -> DOWN; duty decrements every 2 cycles to 0, then state=OFF, busy=0, pwm_out constantly low.
REQ-032 In UP at duty=7, drop ledpin in a tick cycle -> state=DOWN, duty stays 7 in that cycle, then 6 on the next tick; raise ledpin again -> UP, ramps from the current value.
REQ-033 Assert reset in UP at duty=9 -> next edge: duty=0, state=OFF, pwm_out=0; reset to 0 is checked even though ledpin=1.
REQ-034 Gamma build, duty=15 -> cmp=14; duty=4 -> cmp=1; duty=3 -> cmp=0, pwm_out constantly low.
